// File: rtl/noc_imem_pkg.sv
// Shared types and constants for the NoC instruction-memory loader:
// FSM states, error codes and header field positions.
package noc_imem_pkg;

    localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_CSUM,
        ST_VERIFY,
        ST_DRAIN
    } state_e;

    localparam logic [2:0] ERR_NONE   = 3'd0;
    localparam logic [2:0] ERR_MAGIC  = 3'd1;
    localparam logic [2:0] ERR_SHORT  = 3'd2;
    localparam logic [2:0] ERR_CSUM   = 3'd3;
    localparam logic [2:0] ERR_NO_EOP = 3'd4;
    localparam logic [2:0] ERR_VERIFY = 3'd5;

    localparam int HDR_MAGIC_LSB = 24;
    localparam int HDR_COUNT_LSB = 12;
    localparam int HDR_BASE_LSB  = 0;

endpackage

// File: rtl/noc_imem_loader.sv
// Packet-driven loader: writes a NoC load packet into the tile instruction
// memory, verifies the image by read-back checksum and holds the CPU in reset meanwhile.
module noc_imem_loader
    import noc_imem_pkg::*;
#(
    parameter int unsigned ADDR_W = 12,
    parameter logic [7:0]  MAGIC  = MAGIC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       in_data,
    input  logic              in_valid,
    input  logic              in_eop,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    input  logic [31:0]       mem_readdata,
    output logic              cpu_reset_req,
    output logic              load_done,
    output logic              load_err,
    output logic [2:0]        err_code
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    state_e            state_q;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  wr_idx_q;
    logic [CNT_W-1:0]  rd_idx_q;
    logic [CNT_W-1:0]  cap_idx_q;
    logic [31:0]       wsum_q;
    logic [31:0]       rsum_q;
    logic              rd_pend_q;
    logic              cpu_reset_q;
    logic              done_q;
    logic              err_q;
    logic [2:0]        err_code_q;

    logic        accept;
    logic [31:0] wsum_d;
    logic [31:0] rsum_d;
    logic        wr_last;
    logic        rd_issue;
    logic        rd_last;

    assign accept   = in_valid && in_ready;
    assign wsum_d   = wsum_q + in_data;
    assign rsum_d   = rsum_q + mem_readdata;
    assign wr_last  = (wr_idx_q + CNT_W'(1)) == count_q;
    assign rd_issue = (state_q == ST_VERIFY) && (rd_idx_q < count_q);
    assign rd_last  = rd_pend_q && ((cap_idx_q + CNT_W'(1)) == count_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            count_q     <= '0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            cap_idx_q   <= '0;
            wsum_q      <= '0;
            rsum_q      <= '0;
            rd_pend_q   <= 1'b0;
            cpu_reset_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // A successful load keeps the CPU in reset through its load_done cycle.
                    cpu_reset_q <= 1'b0;
                    if (accept) begin
                        if (in_data[HDR_MAGIC_LSB +: 8] != MAGIC) begin
                            err_code_q <= ERR_MAGIC;
                            err_q      <= 1'b1;
                            state_q    <= in_eop ? ST_IDLE : ST_DRAIN;
                        end else if (in_eop) begin
                            err_code_q <= ERR_SHORT;
                            err_q      <= 1'b1;
                        end else begin
                            base_q      <= in_data[HDR_BASE_LSB +: ADDR_W];
                            count_q     <= {1'b0, in_data[HDR_COUNT_LSB +: ADDR_W]} + CNT_W'(1);
                            wr_idx_q    <= '0;
                            wsum_q      <= '0;
                            cpu_reset_q <= 1'b1;
                            err_code_q  <= ERR_NONE;
                            state_q     <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (accept) begin
                        wsum_q   <= wsum_d;
                        wr_idx_q <= wr_idx_q + CNT_W'(1);
                        if (in_eop) begin
                            err_code_q  <= ERR_SHORT;
                            err_q       <= 1'b1;
                            cpu_reset_q <= 1'b0;
                            state_q     <= ST_IDLE;
                        end else if (wr_last) begin
                            state_q <= ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    if (accept) begin
                        if (!in_eop) begin
                            err_code_q  <= ERR_NO_EOP;
                            err_q       <= 1'b1;
                            cpu_reset_q <= 1'b0;
                            state_q     <= ST_DRAIN;
                        end else if (in_data != wsum_q) begin
                            err_code_q  <= ERR_CSUM;
                            err_q       <= 1'b1;
                            cpu_reset_q <= 1'b0;
                            state_q     <= ST_IDLE;
                        end else begin
                            rd_idx_q  <= '0;
                            cap_idx_q <= '0;
                            rsum_q    <= '0;
                            rd_pend_q <= 1'b0;
                            state_q   <= ST_VERIFY;
                        end
                    end
                end
                ST_VERIFY: begin
                    // Read data lags its address by one cycle, so capture trails issue.
                    rd_pend_q <= rd_issue;
                    if (rd_issue) begin
                        rd_idx_q <= rd_idx_q + CNT_W'(1);
                    end
                    if (rd_pend_q) begin
                        rsum_q    <= rsum_d;
                        cap_idx_q <= cap_idx_q + CNT_W'(1);
                    end
                    if (rd_last) begin
                        state_q <= ST_IDLE;
                        if (rsum_d == wsum_q) begin
                            done_q     <= 1'b1;
                            err_code_q <= ERR_NONE;
                        end else begin
                            err_q       <= 1'b1;
                            err_code_q  <= ERR_VERIFY;
                            cpu_reset_q <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (accept && in_eop) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // The write port follows the accepted flit combinationally so payload streams at full rate.
    always_comb begin
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_writedata  = '0;
        if (state_q == ST_WRITE && in_valid) begin
            mem_chipselect = 1'b1;
            mem_write      = 1'b1;
            mem_address    = base_q + wr_idx_q[ADDR_W-1:0];
            mem_writedata  = in_data;
        end else if (rd_issue) begin
            mem_chipselect = 1'b1;
            mem_address    = base_q + rd_idx_q[ADDR_W-1:0];
        end
    end

    assign in_ready       = (state_q != ST_VERIFY);
    assign mem_byteenable = {4{mem_chipselect}};
    assign mem_clken      = 1'b1;
    assign cpu_reset_req  = cpu_reset_q;
    assign load_done      = done_q;
    assign load_err       = err_q;
    assign err_code       = err_code_q;

endmodule

// File: tb/tb_noc_imem_loader.sv
// Self-checking bench for noc_imem_loader: a cycle table for the basic load,
// then scoreboarded packet sequences for wrap, error paths and mid-load reset.
module tb_noc_imem_loader;
    import noc_imem_pkg::*;

    logic        clk = 1'b0;
    logic        resetN;
    logic [31:0] inData;
    logic        inValid;
    logic        inEop;
    logic        inReady;
    logic [11:0] memAddress;
    logic [3:0]  memByteEnable;
    logic        memChipSelect;
    logic        memWrite;
    logic [31:0] memWriteData;
    logic        memClkEn;
    logic [31:0] memReadData;
    logic        cpuResetReq;
    logic        loadDone;
    logic        loadErr;
    logic [2:0]  errCode;

    int nChecks = 0;
    int nPass   = 0;

    logic [31:0] memArr [0:4095];
    logic        faultOn = 1'b0;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;
    typedef struct {
        logic       done;
        logic [2:0] code;
    } ev_t;
    typedef struct {
        logic [31:0] data;
        logic        valid;
        logic        eop;
        logic        ready;
        logic        cs;
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        cpu;
        logic        done;
        logic        err;
        logic [2:0]  code;
    } vec_t;

    wr_t         expWrQ[$];
    logic [11:0] expRdQ[$];
    ev_t         expEvQ[$];
    vec_t        vecs[13];

    noc_imem_loader #(.ADDR_W(12), .MAGIC(8'hA5)) dut (
        .clk(clk),
        .reset_n(resetN),
        .in_data(inData),
        .in_valid(inValid),
        .in_eop(inEop),
        .in_ready(inReady),
        .mem_address(memAddress),
        .mem_byteenable(memByteEnable),
        .mem_chipselect(memChipSelect),
        .mem_write(memWrite),
        .mem_writedata(memWriteData),
        .mem_clken(memClkEn),
        .mem_readdata(memReadData),
        .cpu_reset_req(cpuResetReq),
        .load_done(loadDone),
        .load_err(loadErr),
        .err_code(errCode)
    );

    always #5 clk = ~clk;

    // Memory model with one-cycle read latency and an optional stuck-at-zero word at 0x011.
    always @(posedge clk) begin
        if (memChipSelect && memWrite) begin
            memArr[memAddress] <= memWriteData;
        end
        if (memChipSelect && !memWrite) begin
            memReadData <= (faultOn && memAddress == 12'h011) ? 32'h0 : memArr[memAddress];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every strobe and completion pulse must match a queued expectation.
    always @(negedge clk) begin
        if (resetN) begin
            checkOutput("byteEnable", {28'h0, memByteEnable}, memChipSelect ? 32'hF : 32'h0);
            checkOutput("clkEn", {31'h0, memClkEn}, 32'h1);
            if (memChipSelect && memWrite) begin
                if (expWrQ.size() == 0) begin
                    nChecks++;
                    $display("[TB] FAIL unexpectedWrite: got addr 0x%0h data 0x%0h, expected none", memAddress, memWriteData);
                end else begin
                    wr_t e;
                    e = expWrQ.pop_front();
                    checkOutput("wrAddr", {20'h0, memAddress}, {20'h0, e.addr});
                    checkOutput("wrData", memWriteData, e.data);
                end
            end
            if (memChipSelect && !memWrite) begin
                if (expRdQ.size() == 0) begin
                    nChecks++;
                    $display("[TB] FAIL unexpectedRead: got addr 0x%0h, expected none", memAddress);
                end else begin
                    logic [11:0] a;
                    a = expRdQ.pop_front();
                    checkOutput("rdAddr", {20'h0, memAddress}, {20'h0, a});
                end
            end
            if (loadDone || loadErr) begin
                if (expEvQ.size() == 0) begin
                    nChecks++;
                    $display("[TB] FAIL unexpectedPulse: got done=%0b err=%0b code=%0d, expected none", loadDone, loadErr, errCode);
                end else begin
                    ev_t ev;
                    ev = expEvQ.pop_front();
                    checkOutput("evDone", {31'h0, loadDone}, {31'h0, ev.done});
                    checkOutput("evErr", {31'h0, loadErr}, {31'h0, !ev.done});
                    checkOutput("evCode", {29'h0, errCode}, {29'h0, ev.code});
                end
            end
        end
    end

    function automatic vec_t mkVec(input logic [31:0] d, input logic v, input logic e,
                                   input logic rdy, input logic cs, input logic wr,
                                   input logic [11:0] a, input logic [31:0] wd, input logic cpu,
                                   input logic dn, input logic er, input logic [2:0] cd);
        vec_t r;
        r.data = d; r.valid = v; r.eop = e; r.ready = rdy; r.cs = cs; r.wr = wr;
        r.addr = a; r.wdata = wd; r.cpu = cpu; r.done = dn; r.err = er; r.code = cd;
        return r;
    endfunction

    task automatic pushWrite(input logic [11:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        expWrQ.push_back(w);
    endtask

    task automatic pushEvent(input logic dn, input logic [2:0] cd);
        ev_t ev;
        ev.done = dn;
        ev.code = cd;
        expEvQ.push_back(ev);
    endtask

    // Called just after a rising edge; holds the flit until it is accepted.
    task automatic sendFlit(input logic [31:0] d, input logic e);
        logic rdy;
        int   guard;
        guard   = 0;
        inData  = d;
        inValid = 1'b1;
        inEop   = e;
        do begin
            @(negedge clk);
            rdy = inReady;
            @(posedge clk);
            #1;
            guard++;
        end while (!rdy && guard < 50);
        if (!rdy) begin
            nChecks++;
            $display("[TB] FAIL sendFlitTimeout: got in_ready=0, expected 1 within 50 cycles");
        end
        inValid = 1'b0;
        inEop   = 1'b0;
        inData  = 32'h0;
    endtask

    task automatic waitCompletion(output int cyc, output logic cpuAt);
        cyc   = 0;
        cpuAt = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(loadDone || loadErr) && cyc < 200);
        if (loadDone || loadErr) begin
            cpuAt = cpuResetReq;
        end else begin
            nChecks++;
            $display("[TB] FAIL completionTimeout: got no pulse, expected one within 200 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        inData  = v.data;
        inValid = v.valid;
        inEop   = v.eop;
        if (v.cs && v.wr)  pushWrite(v.addr, v.wdata);
        if (v.cs && !v.wr) expRdQ.push_back(v.addr);
        if (v.done || v.err) pushEvent(v.done, v.code);
        @(negedge clk);
        checkOutput("tblReady", {31'h0, inReady}, {31'h0, v.ready});
        checkOutput("tblCs", {31'h0, memChipSelect}, {31'h0, v.cs});
        checkOutput("tblWrite", {31'h0, memWrite}, {31'h0, v.wr});
        checkOutput("tblAddr", {20'h0, memAddress}, {20'h0, v.addr});
        checkOutput("tblWdata", memWriteData, v.wdata);
        checkOutput("tblCpuReset", {31'h0, cpuResetReq}, {31'h0, v.cpu});
        checkOutput("tblDone", {31'h0, loadDone}, {31'h0, v.done});
        checkOutput("tblErr", {31'h0, loadErr}, {31'h0, v.err});
        checkOutput("tblCode", {29'h0, errCode}, {29'h0, v.code});
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "Ready"}, {31'h0, inReady}, 32'h1);
        checkOutput({tag, "Cs"}, {31'h0, memChipSelect}, 32'h0);
        checkOutput({tag, "Write"}, {31'h0, memWrite}, 32'h0);
        checkOutput({tag, "ByteEn"}, {28'h0, memByteEnable}, 32'h0);
        checkOutput({tag, "Addr"}, {20'h0, memAddress}, 32'h0);
        checkOutput({tag, "Wdata"}, memWriteData, 32'h0);
        checkOutput({tag, "ClkEn"}, {31'h0, memClkEn}, 32'h1);
        checkOutput({tag, "CpuReset"}, {31'h0, cpuResetReq}, 32'h0);
        checkOutput({tag, "Done"}, {31'h0, loadDone}, 32'h0);
        checkOutput({tag, "Err"}, {31'h0, loadErr}, 32'h0);
        checkOutput({tag, "Code"}, {29'h0, errCode}, 32'h0);
    endtask

    initial begin
        int   lat;
        logic cpuAt;

        // Basic load: count 4 at base 0x010, one row per cycle.
        vecs[0]  = mkVec(32'hA5003010, 1, 0, 1, 0, 0, 12'h000, 32'h0, 0, 0, 0, 3'd0);
        vecs[1]  = mkVec(32'h1,        1, 0, 1, 1, 1, 12'h010, 32'h1, 1, 0, 0, 3'd0);
        vecs[2]  = mkVec(32'h2,        1, 0, 1, 1, 1, 12'h011, 32'h2, 1, 0, 0, 3'd0);
        vecs[3]  = mkVec(32'h3,        1, 0, 1, 1, 1, 12'h012, 32'h3, 1, 0, 0, 3'd0);
        vecs[4]  = mkVec(32'h4,        1, 0, 1, 1, 1, 12'h013, 32'h4, 1, 0, 0, 3'd0);
        vecs[5]  = mkVec(32'd10,       1, 1, 1, 0, 0, 12'h000, 32'h0, 1, 0, 0, 3'd0);
        vecs[6]  = mkVec(32'h0,        0, 0, 0, 1, 0, 12'h010, 32'h0, 1, 0, 0, 3'd0);
        vecs[7]  = mkVec(32'h0,        0, 0, 0, 1, 0, 12'h011, 32'h0, 1, 0, 0, 3'd0);
        vecs[8]  = mkVec(32'h0,        0, 0, 0, 1, 0, 12'h012, 32'h0, 1, 0, 0, 3'd0);
        vecs[9]  = mkVec(32'h0,        0, 0, 0, 1, 0, 12'h013, 32'h0, 1, 0, 0, 3'd0);
        vecs[10] = mkVec(32'h0,        0, 0, 0, 0, 0, 12'h000, 32'h0, 1, 0, 0, 3'd0);
        vecs[11] = mkVec(32'h0,        0, 0, 1, 0, 0, 12'h000, 32'h0, 1, 1, 0, 3'd0);
        vecs[12] = mkVec(32'h0,        0, 0, 1, 0, 0, 12'h000, 32'h0, 0, 0, 0, 3'd0);

        resetN  = 1'b0;
        inData  = 32'h0;
        inValid = 1'b0;
        inEop   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("rst");
        resetN = 1'b1;

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
        end

        // Base 0xFFF wraps to 0x000 for both writes and verify reads.
        pushWrite(12'hFFF, 32'hDEADBEEF);
        pushWrite(12'h000, 32'h1);
        expRdQ.push_back(12'hFFF);
        expRdQ.push_back(12'h000);
        pushEvent(1'b1, ERR_NONE);
        sendFlit(32'hA5001FFF, 1'b0);
        sendFlit(32'hDEADBEEF, 1'b0);
        sendFlit(32'h1, 1'b0);
        sendFlit(32'hDEADBEF0, 1'b1);
        waitCompletion(lat, cpuAt);
        checkOutput("wrapLatency", lat, 32'd4);
        checkOutput("wrapCpuAtDone", {31'h0, cpuAt}, 32'h1);

        // Bad magic: error after the header, remaining flits drained, no strobes.
        pushEvent(1'b0, ERR_MAGIC);
        sendFlit(32'h5A000000, 1'b0);
        checkOutput("magicCpu", {31'h0, cpuResetReq}, 32'h0);
        sendFlit(32'h11111111, 1'b0);
        sendFlit(32'h22222222, 1'b0);
        checkOutput("magicDrainCpu", {31'h0, cpuResetReq}, 32'h0);
        sendFlit(32'h33333333, 1'b1);
        checkOutput("magicCodeHeld", {29'h0, errCode}, {29'h0, ERR_MAGIC});

        // Eop on the second of four payload flits, then a good one-word packet.
        pushWrite(12'h020, 32'hA);
        pushWrite(12'h021, 32'hB);
        pushEvent(1'b0, ERR_SHORT);
        sendFlit(32'hA5003020, 1'b0);
        sendFlit(32'hA, 1'b0);
        sendFlit(32'hB, 1'b1);
        waitCompletion(lat, cpuAt);
        checkOutput("shortLatency", lat, 32'd1);
        checkOutput("shortCpuAtErr", {31'h0, cpuAt}, 32'h0);
        pushWrite(12'h100, 32'h7);
        expRdQ.push_back(12'h100);
        pushEvent(1'b1, ERR_NONE);
        sendFlit(32'hA5000100, 1'b0);
        sendFlit(32'h7, 1'b0);
        sendFlit(32'h7, 1'b1);
        waitCompletion(lat, cpuAt);
        checkOutput("recoverLatency", lat, 32'd3);
        checkOutput("recoverCode", {29'h0, errCode}, {29'h0, ERR_NONE});

        // Checksum off by one: error, no verify reads.
        for (int i = 0; i < 4; i++) pushWrite(12'h030 + 12'(i), 32'(i + 1));
        pushEvent(1'b0, ERR_CSUM);
        sendFlit(32'hA5003030, 1'b0);
        for (int i = 0; i < 4; i++) sendFlit(32'(i + 1), 1'b0);
        sendFlit(32'd11, 1'b1);
        waitCompletion(lat, cpuAt);
        checkOutput("csumLatency", lat, 32'd1);
        checkOutput("csumCpuAtErr", {31'h0, cpuAt}, 32'h0);

        // Stuck-at-zero word at 0x011 makes the read-back sum disagree.
        faultOn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pushWrite(12'h010 + 12'(i), 32'(i + 5));
            expRdQ.push_back(12'h010 + 12'(i));
        end
        pushEvent(1'b0, ERR_VERIFY);
        sendFlit(32'hA5003010, 1'b0);
        for (int i = 0; i < 4; i++) sendFlit(32'(i + 5), 1'b0);
        sendFlit(32'd26, 1'b1);
        waitCompletion(lat, cpuAt);
        checkOutput("verifyLatency", lat, 32'd6);
        checkOutput("verifyCode", {29'h0, errCode}, {29'h0, ERR_VERIFY});
        faultOn = 1'b0;

        // Reset pulsed mid-WRITE returns every output to its reset value at once.
        pushWrite(12'h040, 32'h11);
        pushWrite(12'h041, 32'h22);
        sendFlit(32'hA5003040, 1'b0);
        sendFlit(32'h11, 1'b0);
        sendFlit(32'h22, 1'b0);
        inData  = 32'h33;
        inValid = 1'b1;
        #1;
        checkOutput("preResetCs", {31'h0, memChipSelect}, 32'h1);
        checkOutput("preResetCpu", {31'h0, cpuResetReq}, 32'h1);
        resetN = 1'b0;
        #1;
        checkResetOutputs("midRst");
        inValid = 1'b0;
        inData  = 32'h0;
        @(posedge clk);
        #1;
        resetN = 1'b1;

        pushWrite(12'h200, 32'h9);
        expRdQ.push_back(12'h200);
        pushEvent(1'b1, ERR_NONE);
        sendFlit(32'hA5000200, 1'b0);
        sendFlit(32'h9, 1'b0);
        sendFlit(32'h9, 1'b1);
        waitCompletion(lat, cpuAt);
        checkOutput("postResetLatency", lat, 32'd3);

        repeat (2) @(posedge clk);
        checkOutput("wrQueueEmpty", expWrQ.size(), 32'd0);
        checkOutput("rdQueueEmpty", expRdQ.size(), 32'd0);
        checkOutput("evQueueEmpty", expEvQ.size(), 32'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
